// File: rtl/ntt_coeff_unloader.sv
// Streams N coefficients out of the polynomial SRAM on a valid/ready port, optionally
// re-centring each one from [0,Q) to signed form. Owns the SRAM port only while busy.
module ntt_coeff_unloader #(
  parameter int unsigned N      = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned Q      = 8380417,
  parameter bit          CENTER = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_unload,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done_unload,
  output logic [ADDR_W-1:0] mem_A,
  output logic              mem_CEB,
  output logic              mem_WEB,
  input  logic [DATA_W-1:0] mem_Q,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last
);

  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [DATA_W-1:0] QVal = DATA_W'(Q);
  localparam logic [DATA_W-1:0] Half = DATA_W'((Q - 1) / 2);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [CntW-1:0]   rd_cnt_q;
  logic [CntW-1:0]   wr_cnt_q;
  logic              inflight_q;
  logic              done_q;
  logic [1:0]        fifo_cnt_q;
  logic [DATA_W-1:0] fifo_head_q;
  logic [DATA_W-1:0] fifo_tail_q;

  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;
  logic [DATA_W-1:0] push_val;

  assign dout_valid  = (fifo_cnt_q != 2'd0);
  assign dout_data   = fifo_head_q;
  assign dout_last   = dout_valid && (wr_cnt_q == CntW'(N - 1));
  assign busy        = (state_q != StIdle);
  assign done_unload = done_q;
  assign mem_WEB     = 1'b1;

  // Credit counts words buffered plus the one in flight; a same-cycle pop frees a slot.
  assign pop       = dout_valid && dout_ready;
  assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == StRead) && (rd_cnt_q < CntW'(N)) && (occupancy < 3'd2);
  assign mem_CEB   = ~issue;
  assign mem_A     = issue ? base_q + ADDR_W'(rd_cnt_q) : '0;

  always_comb begin
    push_val = mem_Q;
    if (CENTER && (mem_Q > Half)) begin
      push_val = mem_Q - QVal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      fifo_head_q <= '0;
      fifo_tail_q <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (issue) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (pop)   wr_cnt_q <= wr_cnt_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (start_unload) begin
            base_q   <= base_addr;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            state_q  <= StRead;
          end
        end
        StRead: begin
          if (issue && (rd_cnt_q == CntW'(N - 1))) state_q <= StDrain;
        end
        StDrain: begin
          if (pop && (wr_cnt_q == CntW'(N - 1))) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Head only changes on a pop (or fill from empty), keeping data stable under stall.
      case ({inflight_q, pop})
        2'b10: begin
          if (fifo_cnt_q == 2'd0) fifo_head_q <= push_val;
          else                    fifo_tail_q <= push_val;
          fifo_cnt_q <= fifo_cnt_q + 2'd1;
        end
        2'b01: begin
          fifo_head_q <= fifo_tail_q;
          fifo_cnt_q  <= fifo_cnt_q - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            fifo_head_q <= push_val;
          end else begin
            fifo_head_q <= fifo_tail_q;
            fifo_tail_q <= push_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
